// File: rtl/mc_control_fsm_if.sv
// Controller <-> datapath/IR/memory bundle for the multi-cycle MIPS32 controller.
// master: the controller (consumes IR fields and mem_ready, drives strobes/status).
// slave : the datapath side (drives IR fields and mem_ready, consumes strobes/status).
interface mc_control_fsm_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic [4:0] rt;
    logic       mem_ready;
    logic [2:0] state_o;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mdu_start;
    logic       retire;
    logic       trap;
    logic [1:0] trap_cause;

    modport master (
        input  opcode, funct, rt, mem_ready,
        output state_o, ir_write, pc_write, pc_write_cond, mem_read, mem_write,
               reg_write, mdu_start, retire, trap, trap_cause
    );

    modport slave (
        output opcode, funct, rt, mem_ready,
        input  state_o, ir_write, pc_write, pc_write_cond, mem_read, mem_write,
               reg_write, mdu_start, retire, trap, trap_cause
    );
endinterface

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS32 controller: steps each instruction through
// FETCH/DECODE/EXEC/MEM/MDU/WB, traps on illegal encodings and memory timeouts.
// Ports: clk, rst_n (async active-low), bus (mc_control_fsm_if.master):
//   in : opcode/funct/rt (IR fields), mem_ready
//   out: state_o, datapath strobes, retire pulse, sticky trap + trap_cause
// Outputs are a Moore decode of the state register, except ir_write/pc_write in
// FETCH and retire in MEM, which also follow mem_ready.
module mc_control_fsm #(
    parameter int unsigned MDU_LAT     = 4,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    mc_control_fsm_if.master  bus
);
    localparam int unsigned   CNT_W    = 8;
    localparam logic [CNT_W-1:0] MDU_LAST = CNT_W'(MDU_LAT - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(MEM_TIMEOUT - 1);
    localparam bit            TO_EN    = (MEM_TIMEOUT != 0);

    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_MDU    = 3'd5,
        S_WB     = 3'd6,
        S_TRAP   = 3'd7
    } state_e;

    typedef enum logic [2:0] {
        C_ALU, C_JUMP, C_LINK, C_BRANCH, C_LOAD, C_STORE, C_MDU
    } class_e;

    state_e           state_q, state_d;
    class_e           class_q, class_d, dec_class;
    logic             dec_illegal;
    logic [1:0]       cause_q, cause_d;
    logic [CNT_W-1:0] mdu_cnt_q, mdu_cnt_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

    logic ir_write_c, pc_write_c, pc_write_cond_c, mem_read_c, mem_write_c;
    logic reg_write_c, mdu_start_c, retire_c;

    // Instruction class decode from the IR fields
    always_comb begin
        dec_class   = C_ALU;
        dec_illegal = 1'b0;
        case (bus.opcode)
            6'h00: begin
                case (bus.funct)
                    6'h08:                      dec_class = C_JUMP;
                    6'h09:                      dec_class = C_LINK;
                    6'h11, 6'h13,
                    6'h18, 6'h19, 6'h1A, 6'h1B: dec_class = C_MDU;
                    6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h10, 6'h12,
                    6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                    6'h2A, 6'h2B:               dec_class = C_ALU;
                    default:                    dec_illegal = 1'b1;
                endcase
            end
            6'h01: begin
                if (bus.rt == 5'd0 || bus.rt == 5'd1) dec_class = C_BRANCH;
                else                                  dec_illegal = 1'b1;
            end
            6'h02:                       dec_class = C_JUMP;
            6'h03:                       dec_class = C_LINK;
            6'h04, 6'h05, 6'h06, 6'h07:  dec_class = C_BRANCH;
            6'h08, 6'h09, 6'h0A, 6'h0B,
            6'h0C, 6'h0D, 6'h0E, 6'h0F:  dec_class = C_ALU;
            6'h20, 6'h21, 6'h22, 6'h23,
            6'h24, 6'h25, 6'h26:         dec_class = C_LOAD;
            6'h28, 6'h29, 6'h2A, 6'h2B,
            6'h2E:                       dec_class = C_STORE;
            default:                     dec_illegal = 1'b1;
        endcase
    end

    // Next-state and strobe decode
    always_comb begin
        state_d         = state_q;
        class_d         = class_q;
        cause_d         = cause_q;
        mdu_cnt_d       = mdu_cnt_q;
        wait_cnt_d      = wait_cnt_q;
        ir_write_c      = 1'b0;
        pc_write_c      = 1'b0;
        pc_write_cond_c = 1'b0;
        mem_read_c      = 1'b0;
        mem_write_c     = 1'b0;
        reg_write_c     = 1'b0;
        mdu_start_c     = 1'b0;
        retire_c        = 1'b0;

        case (state_q)
            S_RESET: state_d = S_FETCH;
            S_FETCH: begin
                mem_read_c = 1'b1;
                if (bus.mem_ready) begin
                    ir_write_c = 1'b1;
                    pc_write_c = 1'b1;
                    state_d    = S_DECODE;
                end else if (TO_EN && wait_cnt_q == TO_LAST) begin
                    state_d = S_TRAP;
                    cause_d = 2'd2;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            S_DECODE: begin
                class_d = dec_class;
                if (dec_illegal) begin
                    state_d = S_TRAP;
                    cause_d = 2'd1;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                case (class_q)
                    C_JUMP: begin
                        pc_write_c = 1'b1;
                        retire_c   = 1'b1;
                        state_d    = S_FETCH;
                    end
                    C_LINK: begin
                        pc_write_c = 1'b1;
                        state_d    = S_WB;
                    end
                    C_BRANCH: begin
                        pc_write_cond_c = 1'b1;
                        retire_c        = 1'b1;
                        state_d         = S_FETCH;
                    end
                    C_LOAD, C_STORE: state_d = S_MEM;
                    C_MDU: begin
                        mdu_start_c = 1'b1;
                        state_d     = S_MDU;
                    end
                    default: state_d = S_WB;
                endcase
            end
            S_MEM: begin
                mem_read_c  = (class_q == C_LOAD);
                mem_write_c = (class_q != C_LOAD);
                if (bus.mem_ready) begin
                    if (class_q == C_LOAD) begin
                        state_d = S_WB;
                    end else begin
                        retire_c = 1'b1;
                        state_d  = S_FETCH;
                    end
                end else if (TO_EN && wait_cnt_q == TO_LAST) begin
                    state_d = S_TRAP;
                    cause_d = 2'd3;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            S_MDU: begin
                if (mdu_cnt_q == MDU_LAST) begin
                    retire_c = 1'b1;
                    state_d  = S_FETCH;
                end else begin
                    mdu_cnt_d = mdu_cnt_q + CNT_W'(1);
                end
            end
            S_WB: begin
                reg_write_c = 1'b1;
                retire_c    = 1'b1;
                state_d     = S_FETCH;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_RESET;
        endcase

        // Counters restart on every entry into their waiting states
        if (state_d != state_q && (state_d == S_FETCH || state_d == S_MEM)) begin
            wait_cnt_d = '0;
        end
        if (state_d == S_MDU && state_q != S_MDU) begin
            mdu_cnt_d = '0;
        end
    end

    // State and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_RESET;
            class_q    <= C_ALU;
            cause_q    <= 2'd0;
            mdu_cnt_q  <= '0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            class_q    <= class_d;
            cause_q    <= cause_d;
            mdu_cnt_q  <= mdu_cnt_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign bus.state_o       = state_q;
    assign bus.ir_write      = ir_write_c;
    assign bus.pc_write      = pc_write_c;
    assign bus.pc_write_cond = pc_write_cond_c;
    assign bus.mem_read      = mem_read_c;
    assign bus.mem_write     = mem_write_c;
    assign bus.reg_write     = reg_write_c;
    assign bus.mdu_start     = mdu_start_c;
    assign bus.retire        = retire_c;
    assign bus.trap          = (state_q == S_TRAP);
    assign bus.trap_cause    = cause_q;
endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: two instances (MDU_LAT=4/MEM_TIMEOUT=15 and
// MDU_LAT=1/MEM_TIMEOUT=0) share inputs; the selected one is compared cycle by
// cycle against a per-instruction expected trace built from the instruction class.
module tb_mc_control_fsm;
    localparam int LAT_A = 4;
    localparam int TO_A  = 15;
    localparam int LAT_B = 1;
    localparam int TO_B  = 0;

    localparam int CL_ILL = 0, CL_JUMP = 1, CL_LINK = 2, CL_BRANCH = 3;
    localparam int CL_LOAD = 4, CL_STORE = 5, CL_MDU = 6, CL_ALU = 7;

    localparam logic [2:0] ST_RESET = 3'd0, ST_FETCH = 3'd1, ST_DECODE = 3'd2, ST_EXEC = 3'd3;
    localparam logic [2:0] ST_MEM = 3'd4, ST_MDU = 3'd5, ST_WB = 3'd6, ST_TRAP = 3'd7;

    // strobe vector: ir_write pc_write pc_write_cond mem_read mem_write reg_write mdu_start retire trap
    localparam logic [8:0] B_IRW = 9'h100, B_PCW = 9'h080, B_PCC = 9'h040, B_MRD = 9'h020;
    localparam logic [8:0] B_MWR = 9'h010, B_RGW = 9'h008, B_MDS = 9'h004, B_RET = 9'h002;
    localparam logic [8:0] B_TRP = 9'h001, B_NONE = 9'h000;

    typedef struct packed {
        logic [2:0] st;
        logic [8:0] strb;
        logic [1:0] cause;
        logic       rdy;
        logic       irv;
    } rec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sel = 1'b0;
    logic [5:0] opcode = '0;
    logic [5:0] funct = '0;
    logic [4:0] rt = '0;
    logic       mem_ready = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;
    rec_t trace[$];

    mc_control_fsm_if if_a ();
    mc_control_fsm_if if_b ();

    assign if_a.opcode = opcode;
    assign if_a.funct = funct;
    assign if_a.rt = rt;
    assign if_a.mem_ready = mem_ready;
    assign if_b.opcode = opcode;
    assign if_b.funct = funct;
    assign if_b.rt = rt;
    assign if_b.mem_ready = mem_ready;

    mc_control_fsm #(.MDU_LAT(LAT_A), .MEM_TIMEOUT(TO_A)) dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
    mc_control_fsm #(.MDU_LAT(LAT_B), .MEM_TIMEOUT(TO_B)) dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));

    always #5 clk = ~clk;

    logic [13:0] obs_a, obs_b, obs;
    assign obs_a = {if_a.state_o, if_a.ir_write, if_a.pc_write, if_a.pc_write_cond, if_a.mem_read,
                    if_a.mem_write, if_a.reg_write, if_a.mdu_start, if_a.retire, if_a.trap, if_a.trap_cause};
    assign obs_b = {if_b.state_o, if_b.ir_write, if_b.pc_write, if_b.pc_write_cond, if_b.mem_read,
                    if_b.mem_write, if_b.reg_write, if_b.mdu_start, if_b.retire, if_b.trap, if_b.trap_cause};
    assign obs = sel ? obs_b : obs_a;

    // Reference instruction-class table
    function automatic int classify(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] r);
        if (op == 6'h00) begin
            if (fn == 6'h08) return CL_JUMP;
            if (fn == 6'h09) return CL_LINK;
            if (fn inside {6'h11, 6'h13, [6'h18:6'h1B]}) return CL_MDU;
            if (fn inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h10, 6'h12,
                           [6'h20:6'h27], 6'h2A, 6'h2B}) return CL_ALU;
            return CL_ILL;
        end
        if (op == 6'h01) return (r <= 5'd1) ? CL_BRANCH : CL_ILL;
        if (op == 6'h02) return CL_JUMP;
        if (op == 6'h03) return CL_LINK;
        if (op inside {[6'h04:6'h07]}) return CL_BRANCH;
        if (op inside {[6'h08:6'h0F]}) return CL_ALU;
        if (op inside {[6'h20:6'h26]}) return CL_LOAD;
        if (op inside {6'h28, 6'h29, 6'h2A, 6'h2B, 6'h2E}) return CL_STORE;
        return CL_ILL;
    endfunction

    function automatic void push(input logic [2:0] st, input logic [8:0] strb, input logic [1:0] cause,
                                 input logic rdy, input logic irv);
        rec_t r;
        r.st = st; r.strb = strb; r.cause = cause; r.rdy = rdy; r.irv = irv;
        trace.push_back(r);
    endfunction

    function automatic void add_trap(input logic [1:0] cause);
        for (int i = 0; i < 3; i++) push(ST_TRAP, B_TRP, cause, 1'($urandom), 1'b0);
    endfunction

    // A FETCH/MEM wait: 'waits' low cycles then the ready cycle, or a timeout trap
    function automatic bit add_wait(input logic [2:0] st, input logic [8:0] strb, input logic [8:0] done,
                                    input int waits, input int to, input logic [1:0] cause);
        if (to != 0 && waits >= to) begin
            for (int i = 0; i < to; i++) push(st, strb, 2'd0, 1'b0, 1'b0);
            add_trap(cause);
            return 1'b1;
        end
        for (int i = 0; i < waits; i++) push(st, strb, 2'd0, 1'b0, 1'b0);
        push(st, strb | done, 2'd0, 1'b1, 1'b0);
        return 1'b0;
    endfunction

    function automatic void build(input int cls, input int fw, input int mw, input int lat, input int to);
        trace.delete();
        if (add_wait(ST_FETCH, B_MRD, B_IRW | B_PCW, fw, to, 2'd2)) return;
        push(ST_DECODE, B_NONE, 2'd0, 1'($urandom), 1'b1);
        case (cls)
            CL_ILL: add_trap(2'd1);
            CL_JUMP: push(ST_EXEC, B_PCW | B_RET, 2'd0, 1'($urandom), 1'b1);
            CL_LINK: begin
                push(ST_EXEC, B_PCW, 2'd0, 1'($urandom), 1'b1);
                push(ST_WB, B_RGW | B_RET, 2'd0, 1'($urandom), 1'b0);
            end
            CL_BRANCH: push(ST_EXEC, B_PCC | B_RET, 2'd0, 1'($urandom), 1'b1);
            CL_LOAD: begin
                push(ST_EXEC, B_NONE, 2'd0, 1'($urandom), 1'b1);
                if (!add_wait(ST_MEM, B_MRD, B_NONE, mw, to, 2'd3))
                    push(ST_WB, B_RGW | B_RET, 2'd0, 1'($urandom), 1'b0);
            end
            CL_STORE: begin
                push(ST_EXEC, B_NONE, 2'd0, 1'($urandom), 1'b1);
                void'(add_wait(ST_MEM, B_MWR, B_RET, mw, to, 2'd3));
            end
            CL_MDU: begin
                push(ST_EXEC, B_MDS, 2'd0, 1'($urandom), 1'b1);
                for (int i = 0; i < lat; i++)
                    push(ST_MDU, (i == lat - 1) ? B_RET : B_NONE, 2'd0, 1'($urandom), 1'b0);
            end
            default: begin
                push(ST_EXEC, B_NONE, 2'd0, 1'($urandom), 1'b1);
                push(ST_WB, B_RGW | B_RET, 2'd0, 1'($urandom), 1'b0);
            end
        endcase
    endfunction

    task automatic check(input string tag, input logic [13:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Runs one instruction (at most 'limit' cycles); returns 1 if it ended in TRAP
    task automatic do_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                            input logic [4:0] r, input int fw, input int mw, input int limit,
                            output bit trapped);
        build(classify(op, fn, r), fw, mw, sel ? LAT_B : LAT_A, sel ? TO_B : TO_A);
        for (int i = 0; i < trace.size() && i < limit; i++) begin
            @(posedge clk);
            #1;
            mem_ready = trace[i].rdy;
            if (trace[i].irv) {opcode, funct, rt} = {op, fn, r};
            else              {opcode, funct, rt} = 17'($urandom);
            @(negedge clk);
            check($sformatf("%s c%0d", name, i), {trace[i].st, trace[i].strb, trace[i].cause});
        end
        trapped = (trace[trace.size() - 1].st == ST_TRAP);
    endtask

    // Called between a negedge and the following posedge
    task automatic do_reset(input string name);
        #1 rst_n = 1'b0;
        #1 check({name, " async"}, 14'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check({name, " released"}, {ST_RESET, 11'h0});
    endtask

    task automatic rand_instr(output logic [5:0] op, output logic [5:0] fn, output logic [4:0] r);
        bit want_legal;
        want_legal = ($urandom_range(0, 4) != 0);
        op = '0; fn = '0; r = '0;
        for (int k = 0; k < 200; k++) begin
            op = 6'($urandom);
            fn = 6'($urandom);
            r  = 5'($urandom_range(0, 3));
            if (!want_legal || classify(op, fn, r) != CL_ILL) break;
        end
    endtask

    task automatic rand_run(input string name, input int count);
        logic [5:0] op, fn;
        logic [4:0] r;
        int fw, mw;
        bit tr;
        for (int n = 0; n < count; n++) begin
            rand_instr(op, fn, r);
            fw = ($urandom_range(0, 9) == 0) ? int'($urandom_range(10, 20)) : int'($urandom_range(0, 3));
            mw = ($urandom_range(0, 9) == 0) ? int'($urandom_range(10, 20)) : int'($urandom_range(0, 3));
            do_instr($sformatf("%s%0d op%h fn%h", name, n, op, fn), op, fn, r, fw, mw, 1000, tr);
            if (tr) do_reset($sformatf("%s%0d rst", name, n));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        bit tr;
        sel = 1'b0;
        @(negedge clk);
        check("in reset", 14'h0);
        do_reset("A init");

        do_instr("A ADD", 6'h00, 6'h20, 5'd0, 0, 0, 1000, tr);
        do_instr("A LW", 6'h23, 6'h00, 5'd0, 3, 2, 1000, tr);
        do_instr("A MULT", 6'h00, 6'h18, 5'd0, 0, 0, 1000, tr);
        do_instr("A REGIMM rt2", 6'h01, 6'h00, 5'd2, 0, 0, 1000, tr);
        do_reset("A rst1");
        do_instr("A fn3F", 6'h00, 6'h3F, 5'd0, 0, 0, 1000, tr);
        do_reset("A rst2");
        do_instr("A SW timeout", 6'h2B, 6'h00, 5'd0, 0, 1000, 1000, tr);
        do_reset("A rst3");
        do_instr("A SW ready15", 6'h2B, 6'h00, 5'd0, 0, 14, 1000, tr);
        do_instr("A DIV cut", 6'h00, 6'h1A, 5'd0, 0, 0, 5, tr);
        do_reset("A DIV rst");
        do_instr("A J after", 6'h02, 6'h00, 5'd0, 1, 0, 1000, tr);
        do_instr("A fetch to", 6'h00, 6'h20, 5'd0, 15, 0, 1000, tr);
        do_reset("A rst4");
        do_instr("A fetch 14", 6'h04, 6'h00, 5'd0, 14, 0, 1000, tr);
        rand_run("A r", 80);

        sel = 1'b1;
        do_reset("B init");
        do_instr("B MULT", 6'h00, 6'h18, 5'd0, 0, 0, 1000, tr);
        do_instr("B SW long", 6'h2B, 6'h00, 5'd0, 0, 40, 1000, tr);
        do_instr("B fetch long", 6'h03, 6'h00, 5'd0, 30, 0, 1000, tr);
        do_instr("B LB", 6'h20, 6'h00, 5'd0, 2, 25, 1000, tr);
        rand_run("B r", 80);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
